// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory arbiter.
// Covers FSM states, the owner encoding and doubleword/half-select indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        ABORT_I = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DW_OFF_BITS = 3;
    localparam int I_HALF_BIT  = 2;

endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: clear/enable cycle counter for the arbiter bus watchdog.
// Flags when the count equals TIMEOUT.
module arb_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [W-1:0] count;

    // Count busy cycles; cleared while the arbiter sits idle
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == W'(TIMEOUT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port variable-latency memory
// between instruction fetch and the MEM stage, one access at a time.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_abort,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam int         HALF       = DATA_W / 2;

    arb_state_t state;
    logic [3:0] streak;
    logic       i_half;
    logic       tmo_hit;
    logic       i_elig;
    logic       d_elig;
    logic       pick_vld;
    owner_t     pick;
    logic       unused_bits;

    assign unused_bits = ^i_addr[I_HALF_BIT-1:0];

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    // Choose next owner: data wins unless a waiting fetch hit the streak cap
    always_comb begin
        i_elig   = i_req & ~i_done;
        d_elig   = d_req & ~d_done;
        pick     = OWN_I;
        pick_vld = 1'b0;
        if (d_elig && !(i_elig && streak == STREAK_MAX)) begin
            pick     = OWN_D;
            pick_vld = 1'b1;
        end else if (i_elig) begin
            pick_vld = 1'b1;
        end
    end

    arb_timeout_counter #(
        .TIMEOUT(TIMEOUT),
        .W      (8)
    ) u_tmo (
        .clk  (clk),
        .reset(reset),
        .clr  (state == IDLE),
        .en   (state != IDLE),
        .hit  (tmo_hit)
    );

    // Transaction sequencer with registered memory and completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            i_half    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld && pick == OWN_D) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!i_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (pick_vld) begin
                        state    <= BUSY_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {i_addr[ADDR_W-1:DW_OFF_BITS],
                                     {DW_OFF_BITS{1'b0}}};
                        i_half   <= i_addr[I_HALF_BIT];
                        streak   <= '0;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_done  <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_done  <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!i_abort) begin
                            i_done  <= 1'b1;
                            i_rdata <= i_half ? mem_rdata[DATA_W-1:HALF]
                                              : mem_rdata[HALF-1:0];
                        end
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!i_abort) begin
                            i_done <= 1'b1;
                            err    <= 1'b1;
                        end
                    end else if (i_abort) begin
                        state <= ABORT_I;
                    end
                end
                ABORT_I: begin
                    if (mem_ack || tmo_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random stimulus against a
// transaction-level reference model of the arbiter.
module tb_unified_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_abort, d_req, d_we, mem_ack;
    logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata;
    logic [63:0] d_rdata, mem_addr, mem_wdata;
    logic        i_done, i_stall, d_done, d_stall, err;
    logic        mem_req, mem_we;

    int n_chk = 0;
    int n_fail = 0;

    // memory responder controls
    int          mem_cnt = -1;
    int          lat = 1;
    bit          rnd_lat = 0;
    bit          mute = 0;
    bit          late_ack = 0;
    bit          fixed_data = 0;
    logic [63:0] rd_val = '0;

    // reference model: who owns the bus, how long it has waited
    int          m_own;
    bit          m_abt;
    int          m_age;
    int          m_streak;
    bit          m_half;
    logic        e_mem_req, e_mem_we, e_i_done, e_d_done, e_err;
    logic [63:0] e_mem_addr, e_mem_wdata, e_d_rdata;
    logic [31:0] e_i_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .MAX_D_STREAK(MAXS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_abort  (i_abort),
        .i_rdata  (i_rdata),
        .i_done   (i_done),
        .i_stall  (i_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .d_stall  (d_stall),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_side();
        mem_rdata = {$urandom, $urandom};
        mem_ack   = 1'b0;
        if (reset || !mem_req || mute) begin
            mem_cnt = -1;
        end else begin
            if (mem_cnt < 0)
                mem_cnt = (rnd_lat ? $urandom_range(1, 10) : lat) - 1;
            if (mem_cnt == 0) begin
                mem_ack = 1'b1;
                mem_cnt = -1;
                if (fixed_data) mem_rdata = rd_val;
            end else begin
                mem_cnt--;
            end
        end
        if (late_ack) begin
            mem_ack  = 1'b1;
            late_ack = 0;
        end
    endtask

    task automatic model_step();
        bit di, ii, fin, tmo;
        if (reset) begin
            m_own = 0; m_abt = 0; m_age = 0; m_streak = 0; m_half = 0;
            e_mem_req = 0; e_mem_we = 0; e_i_done = 0; e_d_done = 0;
            e_err = 0; e_mem_addr = '0; e_mem_wdata = '0;
            e_d_rdata = '0; e_i_rdata = '0;
        end else begin
            di = d_req && !e_d_done;
            ii = i_req && !e_i_done;
            e_i_done = 0; e_d_done = 0; e_err = 0;
            if (m_own == 0) begin
                if (di && !(ii && m_streak == MAXS)) begin
                    m_own = 2; m_age = 0;
                    e_mem_req = 1; e_mem_we = d_we;
                    e_mem_addr = d_addr; e_mem_wdata = d_wdata;
                    if (i_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                    else m_streak = 0;
                end else if (ii) begin
                    m_own = 1; m_abt = 0; m_age = 0; m_streak = 0;
                    e_mem_req = 1; e_mem_we = 0;
                    e_mem_addr = i_addr & ~64'h7;
                    m_half = i_addr[2];
                end
            end else begin
                if (m_own == 1 && i_abort) m_abt = 1;
                fin = mem_ack;
                tmo = !mem_ack && m_age == TMO;
                if (fin || tmo) begin
                    e_mem_req = 0;
                    if (m_own == 2) begin
                        e_d_done = 1; e_err = tmo;
                        if (fin && !e_mem_we) e_d_rdata = mem_rdata;
                    end else if (!m_abt) begin
                        e_i_done = 1; e_err = tmo;
                        if (fin) e_i_rdata = m_half ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                    m_own = 0;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("mem_req", {63'd0, mem_req}, {63'd0, e_mem_req});
        chk("mem_we", {63'd0, mem_we}, {63'd0, e_mem_we});
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("i_done", {63'd0, i_done}, {63'd0, e_i_done});
        chk("d_done", {63'd0, d_done}, {63'd0, e_d_done});
        chk("err", {63'd0, err}, {63'd0, e_err});
        chk("i_rdata", {32'd0, i_rdata}, {32'd0, e_i_rdata});
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("i_stall", {63'd0, i_stall}, {63'd0, i_req & ~e_i_done});
        chk("d_stall", {63'd0, d_stall}, {63'd0, d_req & ~e_d_done});
    endtask

    task automatic tick();
        @(negedge clk);
        mem_side();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_done(input bit is_d, input int budget, input string tag);
        bit got;
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            got = is_d ? d_done : i_done;
        end
        chk(tag, {63'd0, got}, 64'd1);
    endtask

    task automatic rand_agents();
        i_abort = 1'b0;
        if (d_req && e_d_done) begin
            d_req = 1'($urandom_range(0, 1));
            d_we = 1'($urandom_range(0, 1));
            d_addr = {$urandom, $urandom} & ~64'h7;
            d_wdata = {$urandom, $urandom};
        end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_addr = {$urandom, $urandom} & ~64'h7;
            d_wdata = {$urandom, $urandom};
        end
        if (i_req && e_i_done) begin
            i_req = ($urandom_range(0, 3) != 0);
            i_addr = {$urandom, $urandom} & ~64'h3;
        end else if (i_req && $urandom_range(0, 11) == 0) begin
            i_abort = 1'b1;
            i_addr = {$urandom, $urandom} & ~64'h3;
        end else if (!i_req) begin
            i_req = 1'($urandom_range(0, 1));
            i_addr = {$urandom, $urandom} & ~64'h3;
        end
    endtask

    initial begin
        bit seen;
        reset = 1; i_req = 0; i_abort = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        reset = 0;
        tick();

        // single fetch, upper half of the doubleword
        fixed_data = 1; lat = 3; rd_val = 64'hAAAA_BBBB_1111_2222;
        i_req = 1; i_addr = 64'h14;
        tick();
        chk("fetch_addr", mem_addr, 64'h10);
        chk("fetch_stall", {63'd0, i_stall}, 64'd1);
        wait_done(0, 20, "fetch_wait");
        chk("fetch_rdata", {32'd0, i_rdata}, 64'hAAAABBBB);
        i_req = 0;
        tick();

        // contention: store wins, fetch follows
        lat = 2; rd_val = 64'h1234_5678_9ABC_DEF0;
        i_req = 1; i_addr = 64'h30;
        d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'h5;
        tick();
        chk("cont_we", {63'd0, mem_we}, 64'd1);
        chk("cont_addr", mem_addr, 64'h40);
        wait_done(1, 20, "cont_d_wait");
        chk("cont_order", {63'd0, i_done}, 64'd0);
        d_req = 0;
        wait_done(0, 20, "cont_i_wait");
        chk("cont_i_rdata", {32'd0, i_rdata}, 64'h9ABCDEF0);
        i_req = 0;
        tick();

        // back-to-back data requests while a fetch waits
        fixed_data = 0; lat = 1;
        i_req = 1; i_addr = 64'h208;
        d_req = 1; d_we = 0; d_addr = 64'h100;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            seen = i_done;
            if (e_d_done) d_addr = d_addr + 64'h8;
        end
        chk("starve_i_served", {63'd0, seen}, 64'd1);
        i_req = 0; d_req = 0;
        tick();
        tick();

        // abort one cycle after the fetch grant
        lat = 5;
        i_req = 1; i_addr = 64'h100;
        tick();
        i_abort = 1; i_req = 0;
        tick();
        i_abort = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (i_done) seen = 1;
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);
        chk("abort_idle", {63'd0, mem_req}, 64'd0);
        fixed_data = 1; lat = 2; rd_val = 64'hCAFE_F00D_0BAD_BEEF;
        i_req = 1; i_addr = 64'h20C;
        tick();
        chk("abort_new_addr", mem_addr, 64'h208);
        wait_done(0, 20, "abort_refetch");
        chk("abort_rdata", {32'd0, i_rdata}, 64'hCAFEF00D);
        i_req = 0;
        tick();

        // load timeout, then a stray ack while idle
        lat = 1; rd_val = 64'h0123_4567_89AB_CDEF;
        d_req = 1; d_we = 0; d_addr = 64'h48;
        wait_done(1, 10, "pre_load");
        chk("pre_load_data", d_rdata, 64'h0123_4567_89AB_CDEF);
        d_req = 0;
        tick();
        mute = 1;
        d_req = 1; d_addr = 64'h80;
        wait_done(1, 30, "tmo_wait");
        chk("tmo_err", {63'd0, err}, 64'd1);
        chk("tmo_rdata_kept", d_rdata, 64'h0123_4567_89AB_CDEF);
        chk("tmo_mem_req", {63'd0, mem_req}, 64'd0);
        d_req = 0;
        late_ack = 1;
        tick();
        tick();
        chk("late_ack_ignored", {63'd0, d_done | i_done | err}, 64'd0);
        mute = 0;

        // reset in the middle of a store
        lat = 6;
        d_req = 1; d_we = 1; d_addr = 64'hC0; d_wdata = 64'h77;
        tick();
        tick();
        tick();
        reset = 1;
        tick();
        chk("rst_mid_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mid_addr", mem_addr, 64'd0);
        reset = 0;
        tick();
        chk("rst_regrant", mem_addr, 64'hC0);
        wait_done(1, 20, "rst_regrant_done");
        d_req = 0;
        tick();

        // random traffic with aborts and occasional timeouts
        fixed_data = 0; rnd_lat = 1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            rand_agents();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
